// File: rtl/spi_pkg.sv
// spi_pkg: shared frame geometry, register map and controller FSM states
package spi_pkg;
  localparam int FRAME_W = 16;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;
  localparam logic [ADDR_W-1:0] EN_OUT_7_0 = 7'd0;
  localparam logic [ADDR_W-1:0] EN_OUT_15_8 = 7'd1;
  localparam logic [ADDR_W-1:0] EN_PWM_7_0 = 7'd2;
  localparam logic [ADDR_W-1:0] EN_PWM_15_8 = 7'd3;
  localparam logic [ADDR_W-1:0] PWM_DUTY = 7'd4;
  localparam logic [ADDR_W-1:0] MAX_ADDR = 7'd4;
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
endpackage

// File: rtl/spi_tick_gen.sv
// spi_tick_gen: half-period counter; tick marks the last cycle of each SCLK half-period
module spi_tick_gen #(
  parameter int HALF_PERIOD = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);
  localparam int W = $clog2(HALF_PERIOD);
  localparam logic [W-1:0] LAST = W'(HALF_PERIOD - 1);
  logic [W-1:0] cnt;
  assign tick = cnt == LAST;
  // count 0..HALF_PERIOD-1 and wrap; a frame accept restarts the phase
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (clr || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/spi_controller.sv
// spi_controller: SPI mode-0 initiator sending 16-bit {rw,addr,data} frames.
// Define SPI_CTRL_ADDR_CHECK_EN to reject addresses above MAX_ADDR with an err pulse.
module spi_controller
  import spi_pkg::*;
#(
  parameter int HALF_PERIOD = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              done,
  output logic              err,
  output logic              SCLK,
  output logic              COPI,
  output logic              nCS
);
  if (HALF_PERIOD < 4) begin : g_hp_check
    $error("HALF_PERIOD must be >= 4");
  end
  state_t state, state_n;
  logic [4:0] bit_cnt, bit_n;
  logic [FRAME_W-1:0] sr, sr_n;
  logic sclk_n, copi_n, ncs_n, done_n, err_n, ready_n, tick, accept, bad;
  assign accept = req_valid && req_ready;
`ifdef SPI_CTRL_ADDR_CHECK_EN
  assign bad = req_addr > MAX_ADDR;
`else
  assign bad = 1'b0;
`endif
  spi_tick_gen #(.HALF_PERIOD(HALF_PERIOD)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (accept),
    .tick (tick)
  );
  // next state plus next values of every registered output, decoded from the next state
  always_comb begin
    state_n = state;
    bit_n = bit_cnt;
    sr_n = sr;
    sclk_n = SCLK;
    done_n = 1'b0;
    err_n = accept && bad;
    case (state)
      IDLE: if (accept && !bad) begin
        state_n = SETUP;
        sr_n = {req_rw, req_addr, req_data};
        bit_n = '0;
      end
      SETUP: if (tick) begin
        state_n = SHIFT;
        sclk_n = 1'b1;
      end
      SHIFT: if (tick) begin
        if (SCLK) begin
          sclk_n = 1'b0;
          sr_n = {sr[FRAME_W-2:0], 1'b0};
          bit_n = bit_cnt + 5'd1;
        end else if (bit_cnt == 5'd16) state_n = HOLD;
        else sclk_n = 1'b1;
      end
      HOLD: if (tick) begin
        state_n = GAP;
        done_n = 1'b1;
        bit_n = '0;
      end
      GAP: if (tick) begin
        state_n = bit_cnt[0] ? IDLE : GAP;
        bit_n = 5'd1;
      end
      default: state_n = IDLE;
    endcase
    ncs_n = state_n == IDLE || state_n == GAP;
    copi_n = (state_n == SETUP || state_n == SHIFT) && sr_n[FRAME_W-1];
    ready_n = state_n == IDLE;
  end
  // state and output registers; reset aborts any frame in flight
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      bit_cnt <= '0;
      sr <= '0;
      SCLK <= 1'b0;
      COPI <= 1'b0;
      nCS <= 1'b1;
      done <= 1'b0;
      err <= 1'b0;
      req_ready <= 1'b1;
    end else begin
      state <= state_n;
      bit_cnt <= bit_n;
      sr <= sr_n;
      SCLK <= sclk_n;
      COPI <= copi_n;
      nCS <= ncs_n;
      done <= done_n;
      err <= err_n;
      req_ready <= ready_n;
    end
endmodule

// File: tb/tb_spi_controller.sv
// tb_spi_controller: directed frames checked through a passive SPI bus monitor
module tb_spi_controller;
  logic clk = 0, rst_n = 0, req_valid = 0, req_rw = 0;
  logic [6:0] req_addr = '0;
  logic [7:0] req_data = '0;
  logic req_ready, done, err, SCLK, COPI, nCS;
  int tests = 0, fails = 0;
  int cyc = 0, nfr = 0, nfall = 0, nd = 0, nrise_all = 0, rdy_t = 0, errs = 0, t0 = 0;
  logic [15:0] fr_bits [16];
  int fr_low [16], fr_rise [16], fr_first [16], fr_pmin [16], fr_pmax [16], fall_t [16], done_t [16];
  logic [15:0] sh = '0;
  int lowc = 0, nr = 0, hrun = 0, lrun = 0, pmin = 0, pmax = 0, fcyc = 0, first = 0;
  logic pncs = 1, psclk = 0, prdy = 1;

  always #5 clk = ~clk;

  spi_controller dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_rw(req_rw), .req_addr(req_addr), .req_data(req_data),
    .done(done), .err(err), .SCLK(SCLK), .COPI(COPI), .nCS(nCS)
  );

  // bus monitor: collects per-frame bits, nCS low time, SCLK phase lengths and event times
  always @(negedge clk) begin
    cyc++;
    if (pncs && !nCS) begin
      fall_t[nfall] = cyc;
      nfall++;
      sh = '0; lowc = 0; nr = 0; pmin = 999; pmax = 0; fcyc = cyc; first = -1;
    end
    if (!nCS) lowc++;
    if (SCLK) hrun++;
    else begin
      if (psclk) begin
        pmin = hrun < pmin ? hrun : pmin;
        pmax = hrun > pmax ? hrun : pmax;
      end
      hrun = 0;
    end
    if (!SCLK) lrun++;
    else if (!psclk) begin
      if (nr > 0) begin
        pmin = lrun < pmin ? lrun : pmin;
        pmax = lrun > pmax ? lrun : pmax;
      end
      lrun = 0;
      if (nr == 0) first = cyc - fcyc;
      sh = {sh[14:0], COPI};
      nr++;
      nrise_all++;
    end
    if (!pncs && nCS) begin
      fr_bits[nfr] = sh; fr_low[nfr] = lowc; fr_rise[nfr] = nr;
      fr_first[nfr] = first; fr_pmin[nfr] = pmin; fr_pmax[nfr] = pmax;
      nfr++;
    end
    if (done) begin
      done_t[nd] = cyc;
      nd++;
    end
    if (err) errs++;
    if (!prdy && req_ready) rdy_t = cyc;
    pncs = nCS; psclk = SCLK; prdy = req_ready;
  end

  task automatic chk(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // present a request; t0 is the monitor count of the cycle before the accept edge
  task automatic start(input logic rw, input logic [6:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    req_rw = rw; req_addr = a; req_data = d; req_valid = 1; t0 = cyc + 1;
    @(posedge clk); #1;
  endtask

  task automatic wait_frames(input int n);
    int b = 0;
    while (nfr < n && b < 1000) begin
      @(posedge clk);
      b++;
    end
    #1;
    chk("frame_wait", nfr, n);
  endtask

  initial begin
    int b, k;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", req_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_sclk", SCLK, 0);
    chk("rst_copi", COPI, 0);
    chk("rst_ncs", nCS, 1);
    rst_n = 1;
    start(1, 7'h00, 8'hA5);
    req_valid = 0;
    wait_frames(1);
    repeat (12) @(posedge clk);
    #1;
    chk("a_bits", fr_bits[0], 16'h80A5);
    chk("a_rises", fr_rise[0], 16);
    chk("a_ncs_low", fr_low[0], 136);
    chk("a_fall", fall_t[0] - t0, 1);
    chk("a_first_rise", fr_first[0], 4);
    chk("a_phase_min", fr_pmin[0], 4);
    chk("a_phase_max", fr_pmax[0], 4);
    chk("a_done_t", done_t[0] - t0, 137);
    chk("a_done_cnt", nd, 1);
    chk("a_ready_t", rdy_t - t0, 145);
    start(0, 7'h55, 8'h3C);
    req_valid = 0;
    wait_frames(2);
    chk("b_bits", fr_bits[1], 16'h553C);
    chk("b_done_t", done_t[1] - t0, 137);
    repeat (12) @(posedge clk);
    start(1, 7'h04, 8'h80);
    req_addr = 7'h01; req_data = 8'hFF;
    repeat (50) @(posedge clk);
    #1 req_valid = 0;
    repeat (5) @(posedge clk);
    #1 req_valid = 1;
    b = 0;
    while (nfall < 4 && b < 1000) begin
      @(posedge clk);
      b++;
    end
    #1 req_valid = 0;
    chk("c_fall_wait", nfall, 4);
    wait_frames(4);
    chk("c_period", fall_t[3] - fall_t[2], 145);
    chk("c_bits0", fr_bits[2], 16'h8480);
    chk("c_bits1", fr_bits[3], 16'h81FF);
    chk("c_ncs_low", fr_low[3], 136);
    repeat (12) @(posedge clk);
    b = nrise_all; k = nd;
    start(1, 7'h02, 8'hC3);
    req_valid = 0;
    while (nrise_all - b < 7 && cyc - t0 < 400) @(posedge clk);
    #1 rst_n = 0;
    #1;
    chk("d_ncs", nCS, 1);
    chk("d_sclk", SCLK, 0);
    chk("d_copi", COPI, 0);
    chk("d_ready", req_ready, 1);
    chk("d_done", done, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    wait_frames(5);
    chk("d_rises", fr_rise[4], 7);
    repeat (200) @(posedge clk);
    chk("d_no_done", nd, k);
    start(0, 7'h7F, 8'h01);
    req_valid = 0;
    wait_frames(6);
    chk("e_bits", fr_bits[5], 16'h7F01);
    chk("e_ncs_low", fr_low[5], 136);
    chk("e_done_t", done_t[nd-1] - t0, 137);
    chk("no_err", errs, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
